// File: rtl/multiplier_datapath.sv
// rtl/multiplier_datapath.sv - X:A:B register datapath for the signed add-shift multiplier.
module multiplier_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr_LD,
    input  logic             ClearA,
    input  logic             Shift,
    input  logic             Add,
    input  logic             Sub,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             M
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             x_q, x_d;

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] sw_ext;
    logic [WIDTH:0] operand;
    logic [WIDTH:0] sum9;

    // One sign-extended adder serves both Add and Sub; Sub inverts the operand and injects carry-in.
    always_comb begin
        a_ext   = {a_q[WIDTH-1], a_q};
        sw_ext  = {SW[WIDTH-1], SW};
        operand = Sub ? ~sw_ext : sw_ext;
        sum9    = a_ext + operand + {{WIDTH{1'b0}}, Sub};
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        x_d = x_q;
        if (Clr_LD) begin
            a_d = '0;
            x_d = 1'b0;
            b_d = SW;
        end else if (ClearA) begin
            a_d = '0;
            x_d = 1'b0;
        end else if (Sub || Add) begin
            x_d = sum9[WIDTH];
            a_d = sum9[WIDTH-1:0];
        end else if (Shift) begin
            a_d = {x_q, a_q[WIDTH-1:1]};
            b_d = {a_q[0], b_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q <= '0;
            b_q <= '0;
            x_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            x_q <= x_d;
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign M    = b_q[0];

endmodule

// File: tb/tb_multiplier_datapath.sv
// tb/tb_multiplier_datapath.sv - scoreboard bench for multiplier_datapath with directed vectors.
module tb_multiplier_datapath;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Clr_LD = 1'b0;
    logic       ClearA = 1'b0;
    logic       Shift = 1'b0;
    logic       Add = 1'b0;
    logic       Sub = 1'b0;
    logic [7:0] SW = 8'h00;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       M;

    multiplier_datapath #(.WIDTH(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr_LD(Clr_LD),
        .ClearA(ClearA),
        .Shift (Shift),
        .Add   (Add),
        .Sub   (Sub),
        .SW    (SW),
        .Aval  (Aval),
        .Bval  (Bval),
        .X     (X),
        .M     (M)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [17:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [17:0] e(input logic x, input logic [7:0] a, input logic [7:0] b);
        return {x, a, b, b[0]};
    endfunction

    // Monitor: registers settle at posedge, so the negedge after a checked step shows its result.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t it;
            logic [17:0] got;
            it  = exp_q.pop_front();
            got = {X, Aval, Bval, M};
            n_cmp++;
            if (got !== it.val) begin
                n_bad++;
                $display("FAIL %s: got X=%b A=%h B=%h M=%b, want X=%b A=%h B=%h M=%b",
                         it.name, got[17], got[16:9], got[8:1], got[0],
                         it.val[17], it.val[16:9], it.val[8:1], it.val[0]);
            end
        end
    end

    // ctl bits: {Reset, Clr_LD, ClearA, Shift, Add, Sub}
    task automatic step(input logic [5:0] ctl, input logic [7:0] sw,
                        input bit chk, input string nm, input logic [17:0] ev);
        exp_t it;
        @(negedge Clk);
        {Reset, Clr_LD, ClearA, Shift, Add, Sub} = ctl;
        SW = sw;
        @(posedge Clk);
        #1;
        if (chk) begin
            it.name = nm;
            it.val  = ev;
            exp_q.push_back(it);
        end
    endtask

    localparam logic [5:0] C_RST = 6'b100000;
    localparam logic [5:0] C_LD  = 6'b010000;
    localparam logic [5:0] C_CA  = 6'b001000;
    localparam logic [5:0] C_SH  = 6'b000100;
    localparam logic [5:0] C_ADD = 6'b000010;
    localparam logic [5:0] C_SUB = 6'b000001;
    localparam logic [5:0] C_NOP = 6'b000000;

    task automatic multiply(input logic [7:0] mplier, input logic [7:0] mcand,
                            input string nm, input logic [17:0] ev);
        logic [7:0] bits;
        bits = mplier;
        step(C_LD, mplier, 1'b0, "", '0);
        for (int i = 0; i < 8; i++) begin
            if (bits[i])
                step((i == 7) ? C_SUB : C_ADD, mcand, 1'b0, "", '0);
            step(C_SH, 8'h5A, (i == 7), nm, ev);
        end
    endtask

    initial begin
        step(C_RST | C_LD, 8'hFF, 1'b1, "reset_over_clrld", e(1'b0, 8'h00, 8'h00));
        step(C_NOP, 8'h77, 1'b1, "hold_after_reset", e(1'b0, 8'h00, 8'h00));

        multiply(8'h07, 8'h05, "mul_7x5", e(1'b0, 8'h00, 8'h23));
        step(C_NOP, 8'h33, 1'b1, "hold_product", e(1'b0, 8'h00, 8'h23));
        multiply(8'hFE, 8'h03, "mul_m2x3", e(1'b1, 8'hFF, 8'hFA));

        step(C_CA, 8'h99, 1'b1, "cleara_keeps_b", e(1'b0, 8'h00, 8'hFA));
        step(C_ADD, 8'h7F, 1'b1, "add_7f", e(1'b0, 8'h7F, 8'hFA));
        step(C_ADD, 8'h01, 1'b1, "add_7f_plus_1", e(1'b0, 8'h80, 8'hFA));
        step(C_CA, 8'h00, 1'b0, "", '0);
        step(C_SUB, 8'h80, 1'b1, "sub_0_minus_80", e(1'b0, 8'h80, 8'hFA));
        step(C_CA, 8'h00, 1'b0, "", '0);
        step(C_ADD, 8'h80, 1'b1, "add_0_plus_80", e(1'b1, 8'h80, 8'hFA));
        step(C_ADD, 8'h80, 1'b1, "add_80_plus_80", e(1'b1, 8'h00, 8'hFA));

        step(C_LD, 8'h02, 1'b0, "", '0);
        step(C_ADD, 8'h80, 1'b0, "", '0);
        step(C_ADD, 8'h81, 1'b1, "setup_x1_a01", e(1'b1, 8'h01, 8'h02));
        step(C_SH, 8'h00, 1'b1, "shift_x1", e(1'b1, 8'h80, 8'h81));

        step(C_LD | C_ADD, 8'h3C, 1'b1, "clrld_over_add", e(1'b0, 8'h00, 8'h3C));
        step(C_ADD, 8'hF0, 1'b0, "", '0);
        step(C_CA | C_SH, 8'h00, 1'b1, "cleara_over_shift", e(1'b0, 8'h00, 8'h3C));
        step(C_ADD, 8'h10, 1'b0, "", '0);
        step(C_ADD | C_SUB, 8'h01, 1'b1, "sub_over_add", e(1'b0, 8'h0F, 8'h3C));
        step(C_ADD | C_SH, 8'h01, 1'b1, "add_over_shift", e(1'b0, 8'h10, 8'h3C));

        step(C_LD, 8'h55, 1'b0, "", '0);
        step(C_ADD, 8'hC0, 1'b0, "", '0);
        step(C_RST | C_SH, 8'h11, 1'b1, "reset_mid_seq", e(1'b0, 8'h00, 8'h00));

        step(C_NOP, 8'h00, 1'b0, "", '0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge Clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
